s_mem_reader: RTL and testbench
===============================

Name: s_mem_reader

Overview:
- Read-side counterpart of the S-array init loop: sequentially reads all 256 bytes of the 8-bit-addressed S RAM after it has been written.
- Streams each byte out over a valid/ready interface.
- Checks every byte against the identity pattern S[i]==i and reports pass/fail with error statistics.
- Sits between the S RAM port, shared via a mux with the init loop, and downstream swap/decrypt or debug logic.

Parameters:
- RD_LATENCY, 1, RAM read latency in clock edges from the address-register update to valid q (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_flag  input  1  a 0->1 transition (sampled) starts a read pass.
- address  output  8  RAM address.
- wren  output  1  RAM write enable; constant 0.
- q  input  8  RAM read data.
- out_data  output  8  byte read from RAM.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- done_flag  output  1  pass complete.
- pass_flag  output  1  pass complete and zero mismatches.
- err_count  output  9  number of mismatching bytes (0..256).
- first_err_addr  output  8  address of the first mismatch.

Behaviour:
- Reset (async, active-high), all outputs to 0:
  - address=0, wren=0, out_data=0, out_valid=0, done_flag=0, pass_flag=0, err_count=0, first_err_addr=0.
  - State=IDLE, start edge register=0.
- Start detect:
  - start_prev is registered each cycle; start_edge = start_flag & ~start_prev.
  - Edges are honoured only in IDLE or DONE and ignored otherwise.
- FSM states: IDLE, READ, OUT, DONE.
  - IDLE: on start_edge, set address=0, clear err_count/first_err_addr/done_flag/pass_flag, go to READ.
  - READ:
    - Dwell exactly RD_LATENCY+1 cycles using an internal wait counter.
    - On the final edge: out_data<=q, out_valid<=1, go to OUT.
    - On the same edge, if q!=address: err_count<=err_count+1, and first_err_addr<=address if err_count==0.
  - OUT:
    - Hold out_data/out_valid stable while out_ready=0.
    - On an edge with out_valid&out_ready, out_valid<=0.
    - If address==8'hFF, go to DONE. Otherwise address<=address+1 and go to READ.
  - DONE:
    - done_flag=1; pass_flag=(err_count==0).
    - address holds at 8'hFF. Status stays stable until the next start_edge, which behaves as in IDLE.
- Timing with out_ready tied high and RD_LATENCY=1:
  - Start sampled at edge E0; first out_valid after E0+2.
  - Period is RD_LATENCY+2 = 3 cycles per byte.
  - done_flag rises on the edge after the 256th handshake, i.e. E0+768.
- Arithmetic:
  - address is 8-bit and never wraps within a pass (termination at 8'hFF).
  - err_count is 9-bit and saturates by construction at 256.
- Boundaries:
  - Reset asserted mid-pass aborts immediately. There is no partial done. After release the block waits in IDLE for a fresh start edge.
  - start_flag held high across DONE does not restart; it must go low then high.
  - out_ready asserted while out_valid=0 has no effect.
  - No byte is skipped or duplicated under any out_ready pattern.

Optional Feature:
- Macro: S_MEM_READER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum, 8 bits: the mod-256 sum of all transferred bytes.
  - Cleared on reset and on start_edge; updated on each out_valid&out_ready edge; stable in DONE.
  - Identity RAM yields 8'h80.
- When undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Identity RAM, out_ready=1, one start pulse:
  - out_data sequence 0x00..0xFF in order; out_valid first high 2 cycles after the start edge.
  - done_flag=1 at start+768 cycles, pass_flag=1, err_count=0.
  - checksum=0x80 if enabled.
- RAM with S[0x10]=0xFF and S[0xA0]=0x00:
  - err_count=2, first_err_addr=0x10, pass_flag=0, done_flag=1.
  - Streamed bytes reflect actual RAM contents.
- out_ready low for 5 cycles while out_data=0x05:
  - out_data/out_valid/address held at 0x05.
  - After out_ready returns, the next byte is 0x06; all 256 bytes are delivered exactly once.
- Reset pulse while address=100:
  - All outputs 0 asynchronously.
  - No activity until a new start edge; the rerun reproduces the full identity result.
- start_flag held high through DONE:
  - No restart and status unchanged.
  - Drop low then high: new pass begins with err_count/done_flag cleared.
- Any pass with RD_LATENCY=2: wren observed 0 on every cycle; per-byte period 4 cycles with out_ready=1.

Source files
------------

// File: rtl/s_mem_reader_if.sv
// Bus bundle for s_mem_reader: the S RAM read port (address/wren/q) and the
// byte stream towards downstream logic (out_data/out_valid/out_ready).
interface s_mem_reader_if;
  logic [7:0] address;
  logic       wren;
  logic [7:0] q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output address, wren, out_data, out_valid,
    input  q, out_ready
  );

  modport slave (
    input  address, wren, out_data, out_valid,
    output q, out_ready
  );
endinterface

// File: rtl/s_mem_reader.sv
// Sequential reader of the 256-byte S RAM: streams each byte out and checks S[i]==i.
// Optional macro S_MEM_READER_CHECKSUM_EN adds an 8-bit running sum of transferred bytes.
module s_mem_reader #(
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_flag,
  s_mem_reader_if.master       sif,
  output logic                 done_flag,
  output logic                 pass_flag,
  output logic [8:0]           err_count,
  output logic [7:0]           first_err_addr
`ifdef S_MEM_READER_CHECKSUM_EN
  ,
  output logic [7:0]           checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

  // READ dwells RD_LATENCY+1 edges, so the counter finishes at RD_LATENCY
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY);

  state_t     state_reg, state_next;
  logic       start_prev_reg;
  logic [1:0] wait_reg, wait_next;
  logic [7:0] address_reg, address_next;
  logic [7:0] out_data_reg, out_data_next;
  logic       out_valid_reg, out_valid_next;
  logic       done_reg, done_next;
  logic       pass_reg, pass_next;
  logic [8:0] err_reg, err_next;
  logic [7:0] first_err_reg, first_err_next;
`ifdef S_MEM_READER_CHECKSUM_EN
  logic [7:0] checksum_reg, checksum_next;
`endif

  logic start_edge;
  logic handshake;

  assign start_edge = start_flag & ~start_prev_reg;
  assign handshake  = out_valid_reg & sif.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b0;
      wait_reg       <= 2'd0;
      address_reg    <= 8'd0;
      out_data_reg   <= 8'd0;
      out_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      pass_reg       <= 1'b0;
      err_reg        <= 9'd0;
      first_err_reg  <= 8'd0;
`ifdef S_MEM_READER_CHECKSUM_EN
      checksum_reg   <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= start_flag;
      wait_reg       <= wait_next;
      address_reg    <= address_next;
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      done_reg       <= done_next;
      pass_reg       <= pass_next;
      err_reg        <= err_next;
      first_err_reg  <= first_err_next;
`ifdef S_MEM_READER_CHECKSUM_EN
      checksum_reg   <= checksum_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    address_next   = address_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    done_next      = done_reg;
    pass_next      = pass_reg;
    err_next       = err_reg;
    first_err_next = first_err_reg;
`ifdef S_MEM_READER_CHECKSUM_EN
    checksum_next  = checksum_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (start_edge) begin
          state_next     = READ;
          wait_next      = 2'd0;
          address_next   = 8'd0;
          err_next       = 9'd0;
          first_err_next = 8'd0;
          done_next      = 1'b0;
          pass_next      = 1'b0;
`ifdef S_MEM_READER_CHECKSUM_EN
          checksum_next  = 8'd0;
`endif
        end
      end

      READ: begin
        if (wait_reg == WAIT_LAST) begin
          state_next     = OUT;
          wait_next      = 2'd0;
          out_data_next  = sif.q;
          out_valid_next = 1'b1;
          if (sif.q != address_reg) begin
            err_next = err_reg + 9'd1;
            if (err_reg == 9'd0) begin
              first_err_next = address_reg;
            end
          end
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end

      OUT: begin
        if (handshake) begin
          out_valid_next = 1'b0;
`ifdef S_MEM_READER_CHECKSUM_EN
          checksum_next  = checksum_reg + out_data_reg;
`endif
          // the pass ends on the last byte, so address never wraps
          if (address_reg == 8'hFF) begin
            state_next = DONE;
            done_next  = 1'b1;
            pass_next  = (err_reg == 9'd0);
          end else begin
            state_next   = READ;
            address_next = address_reg + 8'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sif.address    = address_reg;
  assign sif.wren       = 1'b0;
  assign sif.out_data   = out_data_reg;
  assign sif.out_valid  = out_valid_reg;
  assign done_flag      = done_reg;
  assign pass_flag      = pass_reg;
  assign err_count      = err_reg;
  assign first_err_addr = first_err_reg;
`ifdef S_MEM_READER_CHECKSUM_EN
  assign checksum       = checksum_reg;
`endif

endmodule

// File: tb/tb_s_mem_reader.sv
// Bench for s_mem_reader: RAM models with latency 1 and 2, randomised RAM contents and
// out_ready patterns, expected results computed from the RAM array itself.
module tb_s_mem_reader;

  logic clk = 1'b0;
  logic reset;
  logic start1, start2;
  logic done1, pass1, done2, pass2;
  logic [8:0] err1, err2;
  logic [7:0] ferr1, ferr2;
`ifdef S_MEM_READER_CHECKSUM_EN
  logic [7:0] csum1, csum2;
`endif

  s_mem_reader_if sif1();
  s_mem_reader_if sif2();

  s_mem_reader #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start_flag(start1), .sif(sif1),
    .done_flag(done1), .pass_flag(pass1), .err_count(err1), .first_err_addr(ferr1)
`ifdef S_MEM_READER_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  s_mem_reader #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start_flag(start2), .sif(sif2),
    .done_flag(done2), .pass_flag(pass2), .err_count(err2), .first_err_addr(ferr2)
`ifdef S_MEM_READER_CHECKSUM_EN
    , .checksum(csum2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [256];
  logic [7:0] pipe2;
  logic [7:0] hs1_data[$];
  logic [7:0] hs2_data[$];
  int         hs2_cyc[$];

  // RAM models: address registered at the edge, q valid RD_LATENCY edges later
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    sif1.q   <= mem[sif1.address];
    pipe2    <= mem[sif2.address];
    sif2.q   <= pipe2;
  end

  always @(negedge clk) begin
    if (sif1.out_valid && sif1.out_ready) hs1_data.push_back(sif1.out_data);
    if (sif2.out_valid && sif2.out_ready) begin
      hs2_data.push_back(sif2.out_data);
      hs2_cyc.push_back(cyc + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a full pass over mem must report
  task automatic model(output int e, output int f, output logic [7:0] cs);
    e = 0; f = 0; cs = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] != 8'(i)) begin
        if (e == 0) f = i;
        e++;
      end
      cs = cs + mem[i];
    end
  endtask

  task automatic check_stream1(input string tag, input int base);
    int n_bad = 0;
    check({tag, "_count"}, 32'(hs1_data.size() - base), 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (base + i >= hs1_data.size()) n_bad++;
      else if (hs1_data[base + i] !== mem[i]) n_bad++;
    end
    check({tag, "_stream"}, 32'(n_bad), 32'd0);
  endtask

  task automatic check_status1(input string tag);
    int e, f;
    logic [7:0] cs;
    model(e, f, cs);
    check({tag, "_done"}, 32'(done1), 32'd1);
    check({tag, "_err"}, 32'(err1), 32'(e));
    check({tag, "_ferr"}, 32'(ferr1), 32'(f));
    check({tag, "_pass"}, 32'(pass1), 32'(e == 0));
    check({tag, "_addr"}, 32'(sif1.address), 32'hFF);
`ifdef S_MEM_READER_CHECKSUM_EN
    check({tag, "_csum"}, 32'(csum1), 32'(cs));
`endif
    $display("pass %s: bytes=%0d err_count=%0d first_err=%0h pass=%0b",
             tag, hs1_data.size(), err1, ferr1, pass1);
  endtask

  // Start a pass on dut1 (start1 must be low) and run it to completion
  task automatic run_pass(input string tag, input bit rnd_ready, input int exp_first,
                          input int exp_done);
    int base, e0, first, done_at;
    base = hs1_data.size();
    first = -1; done_at = -1;
    start1 = 1'b1;
    tick();
    e0 = cyc;
    for (int k = 0; k < 5000 && done_at < 0; k++) begin
      sif1.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (sif1.out_valid && first < 0) first = cyc - e0;
      if (done1) done_at = cyc - e0;
    end
    sif1.out_ready = 1'b1;
    check({tag, "_finished"}, 32'(done_at >= 0), 32'd1);
    if (exp_first >= 0) check({tag, "_first_valid"}, 32'(first), 32'(exp_first));
    if (exp_done >= 0) check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check_stream1(tag, base);
    check_status1(tag);
  endtask

  initial begin
    int base, e0, first, done_at, n_bad, snap_err, snap_hs, found;
    reset = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    sif1.out_ready = 1'b1;
    sif2.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) tick();

    check("rst_addr", 32'(sif1.address), 32'd0);
    check("rst_wren", 32'(sif1.wren), 32'd0);
    check("rst_data", 32'(sif1.out_data), 32'd0);
    check("rst_valid", 32'(sif1.out_valid), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_pass", 32'(pass1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_ferr", 32'(ferr1), 32'd0);
    check("rst_valid2", 32'(sif2.out_valid), 32'd0);
    reset = 1'b0;
    tick();

    // identity RAM, always ready: exact timing
    run_pass("identity", 1'b0, 2, 768);
    start1 = 1'b0;
    tick();

    // random RAM, random back-pressure
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_pass("random", 1'b1, -1, -1);
    start1 = 1'b0;
    tick();

    // two faults, random back-pressure; start stays high afterwards
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hFF;
    mem[8'hA0] = 8'h00;
    run_pass("two_faults", 1'b1, -1, -1);

    snap_err = 32'(err1);
    snap_hs = hs1_data.size();
    repeat (20) tick();
    check("held_done", 32'(done1), 32'd1);
    check("held_err", 32'(err1), 32'(snap_err));
    check("held_no_bytes", 32'(hs1_data.size()), 32'(snap_hs));
    check("held_valid", 32'(sif1.out_valid), 32'd0);
    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    tick();
    check("restart_done_clr", 32'(done1), 32'd0);
    check("restart_err_clr", 32'(err1), 32'd0);
    done_at = -1;
    for (int k = 0; k < 2000 && done_at < 0; k++) begin
      tick();
      if (done1) done_at = k;
    end
    check("restart_finished", 32'(done_at >= 0), 32'd1);
    check_status1("restart");
    start1 = 1'b0;
    tick();

    // every byte wrong: err_count reaches 256
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    run_pass("all_bad", 1'b0, 2, 768);
    start1 = 1'b0;
    tick();

    // stall on byte 0x05 for 5 cycles
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    base = hs1_data.size();
    start1 = 1'b1;
    tick();
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      tick();
      if (sif1.out_valid && sif1.out_data == 8'h05) found = 1;
    end
    check("stall_reached", 32'(found), 32'd1);
    sif1.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_data", 32'(sif1.out_data), 32'h05);
      check("stall_valid", 32'(sif1.out_valid), 32'd1);
      check("stall_addr", 32'(sif1.address), 32'h05);
    end
    sif1.out_ready = 1'b1;
    done_at = -1;
    for (int k = 0; k < 2000 && done_at < 0; k++) begin
      tick();
      if (done1) done_at = k;
    end
    check("stall_finished", 32'(done_at >= 0), 32'd1);
    check("stall_next_byte", 32'(hs1_data.size() > base + 6 ? hs1_data[base + 6] : 8'hxx), 32'h06);
    check_stream1("stall", base);
    check_status1("stall");
    start1 = 1'b0;
    tick();

    // reset in the middle of a pass
    start1 = 1'b1;
    tick();
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      tick();
      if (sif1.address == 8'd100) found = 1;
    end
    check("mid_reached", 32'(found), 32'd1);
    reset = 1'b1;
    start1 = 1'b0;
    #1;
    check("async_addr", 32'(sif1.address), 32'd0);
    check("async_valid", 32'(sif1.out_valid), 32'd0);
    check("async_data", 32'(sif1.out_data), 32'd0);
    check("async_done", 32'(done1), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    snap_hs = hs1_data.size();
    n_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sif1.out_valid || sif1.address != 8'd0 || done1) n_bad++;
    end
    check("idle_after_reset", 32'(n_bad), 32'd0);
    check("idle_no_bytes", 32'(hs1_data.size()), 32'(snap_hs));
    run_pass("rerun", 1'b0, 2, 768);
    start1 = 1'b0;
    tick();

    // latency-2 instance: 4-cycle period, wren never asserted
    base = hs2_data.size();
    start2 = 1'b1;
    tick();
    e0 = cyc;
    first = -1; done_at = -1; n_bad = 0;
    for (int k = 0; k < 3000 && done_at < 0; k++) begin
      tick();
      if (sif2.wren !== 1'b0) n_bad++;
      if (sif2.out_valid && first < 0) first = cyc - e0;
      if (done2) done_at = cyc - e0;
    end
    check("lat2_wren", 32'(n_bad), 32'd0);
    check("lat2_first_valid", 32'(first), 32'd3);
    check("lat2_done_cycle", 32'(done_at), 32'd1024);
    check("lat2_count", 32'(hs2_data.size() - base), 32'd256);
    n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (base + i >= hs2_data.size()) n_bad++;
      else begin
        if (hs2_data[base + i] !== mem[i]) n_bad++;
        if (i > 0 && hs2_cyc[base + i] - hs2_cyc[base + i - 1] != 4) n_bad++;
      end
    end
    check("lat2_stream_period", 32'(n_bad), 32'd0);
    check("lat2_pass", 32'(pass2), 32'd1);
    check("lat2_err", 32'(err2), 32'd0);
`ifdef S_MEM_READER_CHECKSUM_EN
    check("lat2_csum", 32'(csum2), 32'h80);
`endif
    $display("pass lat2: bytes=%0d err_count=%0d pass=%0b", hs2_data.size() - base, err2, pass2);
    start2 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
